// File: rtl/stats_pkg.sv
// stats_pkg: record layout and beat geometry shared by the stats packers and unpacker
package stats_pkg;
   localparam int STATS_REC_W   = 64;
   localparam int STATS_DATA_W  = 512;
   localparam int RECS_PER_BEAT = STATS_DATA_W / STATS_REC_W;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] val;
   } stats_t;
   typedef enum logic {IDLE, UNPACK} state_e;
   // Records carried by a beat; a misaligned empty on the last beat rounds down.
   function automatic logic [3:0] beat_recs(input logic eop, input logic [5:0] empty);
      return eop ? 4'((7'd64 - {1'b0, empty}) >> 3) : 4'(RECS_PER_BEAT);
   endfunction
endpackage

// File: rtl/stats_regfile.sv
// stats_regfile: NUM_REGS x 32 bank, one write port, registered read-before-write read port
module stats_regfile #(
   parameter int NUM_REGS = 64,
   localparam int IDX_W = $clog2(NUM_REGS)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  logic [31:0]      wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [31:0]      rdata_o,
   output logic             rvalid_o
);
   logic [31:0] mem_q [NUM_REGS];
   logic [31:0] rdata_q;
   logic        rvalid_q;
   // Bank storage, cleared on reset
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end
   // Registered read sees the pre-write contents on a same-cycle collision
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= re_i;
         if (re_i) rdata_q <= mem_q[ridx_i];
      end
   end
   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
endmodule

// File: rtl/stats_unpacker_avlstrm.sv
// stats_unpacker_avlstrm: unpacks Avalon-ST {addr,val} record beats into a readable register bank
module stats_unpacker_avlstrm
   import stats_pkg::*;
#(
   parameter int          DATA_W    = 512,
   parameter int          NUM_REGS  = 64,
   parameter int unsigned ADDR_BASE = 0,
   localparam int IDX_W = $clog2(NUM_REGS)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              stats_in_valid,
   output logic              stats_in_ready,
   input  logic              stats_in_sop,
   input  logic              stats_in_eop,
   input  logic [DATA_W-1:0] stats_in_data,
   input  logic [5:0]        stats_in_empty,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   output logic [31:0]       cnt_rx_pkt,
   output logic [31:0]       cnt_rx_rec,
   output logic [31:0]       cnt_drop_rec,
   output logic [31:0]       cnt_frame_err
);
   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic [3:0]        rec_cnt_q;
   logic [2:0]        rec_idx_q;
   logic              in_pkt_q;
   logic              ready_q, ready_d;
   logic              proc;
   logic [31:0]       pkt_q, rec_q, drop_q, ferr_q;
   logic              accept, last, sop_err, align_err, in_rng;
   logic [3:0]        beat_cnt;
   logic [32:0]       off;
   stats_t            rec;
   assign accept    = stats_in_valid && ready_q;
   assign beat_cnt  = beat_recs(stats_in_eop, stats_in_empty);
   assign sop_err   = stats_in_sop == in_pkt_q;
   assign align_err = stats_in_eop && |stats_in_empty[2:0];
   assign rec       = stats_t'(data_q[DATA_W-1-STATS_REC_W*int'(rec_idx_q) -: STATS_REC_W]);
   assign last      = rec_idx_q == 3'(rec_cnt_q - 4'd1);
   assign off       = {1'b0, rec.addr} - 33'(ADDR_BASE);
   assign in_rng    = ({1'b0, rec.addr} >= 33'(ADDR_BASE)) && (off < 33'(NUM_REGS));
   // FSM state register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // FSM next state: empty beats never leave IDLE
   always_comb begin
      state_d = (state_q == IDLE) ? ((accept && beat_cnt != 4'd0) ? UNPACK : IDLE)
                                  : (last ? IDLE : UNPACK);
   end
   // FSM outputs: ready is registered so it rises one edge after reset or the final record
   always_comb begin
      proc    = state_q == UNPACK;
      ready_d = state_d == IDLE;
   end
   // Beat buffer and record cursor
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ready_q   <= 1'b0;
         data_q    <= '0;
         rec_cnt_q <= '0;
         rec_idx_q <= '0;
      end else begin
         ready_q <= ready_d;
         if (accept) begin
            data_q    <= stats_in_data;
            rec_cnt_q <= beat_cnt;
            rec_idx_q <= '0;
         end else if (proc) begin
            rec_idx_q <= rec_idx_q + 3'd1;
         end
      end
   end
   // Packet framing and wrapping statistics counters
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         in_pkt_q <= 1'b0;
         pkt_q    <= '0;
         rec_q    <= '0;
         drop_q   <= '0;
         ferr_q   <= '0;
      end else begin
         if (accept) begin
            in_pkt_q <= !stats_in_eop;
            pkt_q    <= pkt_q + 32'(stats_in_eop);
            ferr_q   <= ferr_q + 32'(sop_err) + 32'(align_err);
         end
         if (proc) begin
            rec_q  <= rec_q + 32'(in_rng);
            drop_q <= drop_q + 32'(!in_rng);
         end
      end
   end
   stats_regfile #(.NUM_REGS(NUM_REGS)) u_bank (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .we_i     (proc && in_rng),
      .widx_i   (off[IDX_W-1:0]),
      .wdata_i  (rec.val),
      .re_i     (rd_en),
      .ridx_i   (rd_idx),
      .rdata_o  (rd_data),
      .rvalid_o (rd_valid)
   );
   assign stats_in_ready = ready_q;
   assign cnt_rx_pkt     = pkt_q;
   assign cnt_rx_rec     = rec_q;
   assign cnt_drop_rec   = drop_q;
   assign cnt_frame_err  = ferr_q;
endmodule

// File: doc/stats_unpacker_avlstrm.md
Name: stats_unpacker_avlstrm

Overview:
- Receiving end of the statistics stream that the per-service stats packers emit.
- Accepts Avalon-ST packets of packed {addr,val} records and writes each in-range record into a local register bank.
- The host/CSR side reads the bank through a simple read port.
- Sits at the top of the stats network, after the stats mux and before the CSR bridge.

Parameters:
- DATA_W, 512, stream data width; fixed at 8 records of 64 bits per beat.
- NUM_REGS, 64, register bank depth; must be a power of two.
- ADDR_BASE, 0, first stats address owned by this bank.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  reset; asynchronous assert, active-low.
- stats_in_valid  in  1  beat valid.
- stats_in_ready  out  1  beat accepted when valid && ready.
- stats_in_sop  in  1  first beat of packet.
- stats_in_eop  in  1  last beat of packet.
- stats_in_data  in  DATA_W  packed records.
- stats_in_empty  in  6  unused bytes in the eop beat.
- rd_en  in  1  read request.
- rd_idx  in  log2(NUM_REGS)  bank index.
- rd_data  out  32  read value.
- rd_valid  out  1  read response strobe.
- cnt_rx_pkt  out  32  packets completed.
- cnt_rx_rec  out  32  records written.
- cnt_drop_rec  out  32  out-of-range records discarded.
- cnt_frame_err  out  32  framing errors.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, in_pkt=0, stats_in_ready=0, rd_valid=0, rd_data=0, all counters=0, all bank entries=0. First ready is asserted on the first Clk edge after deassertion.
- Record format: record k (k=0..7) is data[511-64k -: 64]. Record 0 is in the MSBs, matching concatenation order. Within a record, addr=[63:32] and val=[31:0] (stats_t).
- Records per beat: 8 on non-eop beats. On eop beats: (64-empty)/8. If empty is not a multiple of 8, truncate (floor) and count a frame error.
- FSM IDLE:
  - stats_in_ready=1.
  - On accept, latch data and rec_cnt into the beat buffer, set rec_idx=0, go to UNPACK.
  - If rec_cnt=0, stay in IDLE.
- FSM UNPACK:
  - stats_in_ready=0.
  - Each cycle, process record rec_idx and increment it.
  - After the last record, return to IDLE; ready rises the following cycle.
  - Throughput: at most 1 record per cycle, so a full beat occupies 9 cycles including the IDLE accept.
- Processing a record:
  - idx = addr-ADDR_BASE.
  - If ADDR_BASE <= addr < ADDR_BASE+NUM_REGS: bank[idx]<=val and cnt_rx_rec++.
  - Otherwise: no write and cnt_drop_rec++.
  - Unsigned compare in 33 bits, so no wrap at 2^32.
- Framing, tracked by the in_pkt flag, updated on accept:
  - Beat without sop while in_pkt=0: records still processed, cnt_frame_err++.
  - sop while in_pkt=1: cnt_frame_err++, treat as a new packet.
  - On an eop beat: in_pkt<=0 and cnt_rx_pkt++.
  - A single-beat packet (sop&&eop) is legal.
- Read port:
  - rd_valid and rd_data are registered, one cycle after rd_en.
  - rd_idx is always in range by width.
  - Read and write to the same idx in the same cycle returns the old value (read-before-write).
  - Back-to-back reads are supported every cycle.
- Counters are 32-bit and wrap silently from 0xFFFFFFFF to 0.
- Reset mid-UNPACK aborts the beat; the remaining records are not written.

Decomposition:
- stats_pkg holds:
  - typedef stats_t {logic[31:0] addr; logic[31:0] val;};
  - STATS_REC_W=64;
  - RECS_PER_BEAT=DATA_W/STATS_REC_W.
  - Shared with stats_packer_avlstrm.
- Sub-module stats_regfile: NUM_REGS x 32 bank with one write port and one registered read port, read-before-write. Keeps the bank replaceable by M20K inference.

Test Plan:
- Reset, then a single-beat packet (sop=eop=1, empty=0) carrying addrs 0..7 with vals 0x100..0x107 -> reads idx 0..7 return 0x100..0x107. cnt_rx_rec=8, cnt_rx_pkt=1, ready low for 8 cycles after accept.
- Two-beat packet, eop beat with empty=40 (3 records, addrs 8..10) -> cnt_rx_rec=11, idx 11 still 0, cnt_frame_err=0.
- ADDR_BASE=16, record addr=15 and addr=80 (NUM_REGS=64) -> cnt_drop_rec=2, no bank change. addr=16 writes idx 0.
- Beat with sop=0 outside a packet, then sop during an open packet -> cnt_frame_err=2, records in both beats still written.
- rd_en idx 3 in the same cycle the FSM writes 0xDEAD to idx 3 -> rd_data returns the old value; a read on the next cycle returns 0xDEAD.
- Rst_n pulsed low during UNPACK at rec_idx=4 -> records 4..7 not written, all counters 0, ready=1 one cycle after release.
